// File: rtl/cpu_defs.sv
// cpu_defs: opcodes, forwarding encodings and the shadow-pipe entry shared by
// the hazard scheduler and its decoder.
package cpu_defs;

   localparam int unsigned OPCODE_W  = 6;
   localparam int unsigned SH_DEST_W = 5;
   localparam int unsigned FWD_W     = 2;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OPCODE_W-1:0] OP_XORI  = 6'b001110;
   localparam logic [OPCODE_W-1:0] OP_SLTIU = 6'b001011;
   localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;

   localparam logic [SH_DEST_W-1:0] JAL_DEST = 5'd31;

   localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
   localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
   localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

   typedef struct packed {
      logic                 valid;
      logic                 wr;
      logic [SH_DEST_W-1:0] dest;
      logic                 is_load;
   } shadow_t;

endpackage

// File: rtl/ins_reg_decode.sv
// ins_reg_decode: extracts register usage (destination, sources, load flag)
// from a MIPS instruction word. Register $0 is never a destination or a source.
module ins_reg_decode
   import cpu_defs::*;
#(
   parameter int unsigned REG_AW = 5
) (
   input  logic [31:0]       i_ir,
   output logic              o_wr,
   output logic [REG_AW-1:0] o_dest,
   output logic [REG_AW-1:0] o_rs,
   output logic [REG_AW-1:0] o_rt,
   output logic              o_use_rs,
   output logic              o_use_rt,
   output logic              o_is_load
);

   logic [OPCODE_W-1:0] w_op;
   logic                w_has_dest;
   logic [REG_AW-1:0]   w_dest;
   logic                w_rd_rs;
   logic                w_rd_rt;
   logic                w_unused_imm;

   assign w_op         = i_ir[31:26];
   assign o_rs         = REG_AW'(i_ir[25:21]);
   assign o_rt         = REG_AW'(i_ir[20:16]);
   assign w_unused_imm = ^i_ir[10:0];

   // Opcode table: which fields are read and written.
   always_comb begin
      w_has_dest = 1'b0;
      w_dest     = '0;
      w_rd_rs    = 1'b0;
      w_rd_rt    = 1'b0;
      o_is_load  = 1'b0;
      case (w_op)
         OP_RTYPE: begin
            w_has_dest = 1'b1;
            w_dest     = REG_AW'(i_ir[15:11]);
            w_rd_rs    = 1'b1;
            w_rd_rt    = 1'b1;
         end
         OP_LW: begin
            w_has_dest = 1'b1;
            w_dest     = o_rt;
            w_rd_rs    = 1'b1;
            o_is_load  = 1'b1;
         end
         OP_SW, OP_BEQ, OP_BNE: begin
            w_rd_rs = 1'b1;
            w_rd_rt = 1'b1;
         end
         OP_ADDI, OP_ANDI, OP_XORI, OP_SLTIU: begin
            w_has_dest = 1'b1;
            w_dest     = o_rt;
            w_rd_rs    = 1'b1;
         end
         OP_JAL: begin
            w_has_dest = 1'b1;
            w_dest     = REG_AW'(JAL_DEST);
         end
         default: ;
      endcase
   end

   assign o_dest   = w_dest;
   assign o_wr     = w_has_dest & (w_dest != '0);
   assign o_use_rs = w_rd_rs & (o_rs != '0);
   assign o_use_rt = w_rd_rt & (o_rt != '0);

endmodule

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: decides each cycle whether the ID instruction issues,
// stalls or is flushed, using a 3-entry shadow of EX/MEM/WB destinations.
// Define HAZARD_FORWARD_EN for operand forwarding (load-use stalls only).
module hazard_scheduler
   import cpu_defs::*;
#(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned STALL_CW = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [31:0]         id_ir,
   input  logic                branch_taken,
   output logic                stall,
   output logic                bubble,
   output logic                flush,
   output logic [FWD_W-1:0]    fwd_a_sel,
   output logic [FWD_W-1:0]    fwd_b_sel,
   output logic [STALL_CW-1:0] stall_count
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_STALL = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic              w_wr;
   logic [REG_AW-1:0] w_dest;
   logic [REG_AW-1:0] w_rs;
   logic [REG_AW-1:0] w_rt;
   logic              w_use_rs;
   logic              w_use_rt;
   logic              w_is_load;

   shadow_t r_ex;
   shadow_t r_mem;
   shadow_t r_wb;
   shadow_t w_id_entry;

   logic w_ex_a, w_ex_b, w_mem_a, w_mem_b;
   logic w_hazard;
   logic w_issue;
   logic w_unused_wb;

   logic [FWD_W-1:0]    w_fwd_a, w_fwd_b;
   logic [FWD_W-1:0]    r_fwd_a, r_fwd_b;
   logic [1:0]          r_state, w_state_nxt;
   logic [STALL_CW-1:0] r_stall_count;

   ins_reg_decode #(.REG_AW(REG_AW)) u_decode (
      .i_ir      (id_ir),
      .o_wr      (w_wr),
      .o_dest    (w_dest),
      .o_rs      (w_rs),
      .o_rt      (w_rt),
      .o_use_rs  (w_use_rs),
      .o_use_rt  (w_use_rt),
      .o_is_load (w_is_load)
   );

   // Source-vs-producer matches; the WB entry writes before ID reads, so it never matters.
   assign w_ex_a  = r_ex.valid  & r_ex.wr  & w_use_rs & (w_rs == REG_AW'(r_ex.dest));
   assign w_ex_b  = r_ex.valid  & r_ex.wr  & w_use_rt & (w_rt == REG_AW'(r_ex.dest));
   assign w_mem_a = r_mem.valid & r_mem.wr & w_use_rs & (w_rs == REG_AW'(r_mem.dest));
   assign w_mem_b = r_mem.valid & r_mem.wr & w_use_rt & (w_rt == REG_AW'(r_mem.dest));
   assign w_unused_wb = ^r_wb;

`ifdef HAZARD_FORWARD_EN
   assign w_hazard = r_ex.is_load & (w_ex_a | w_ex_b);
   assign w_fwd_a  = w_ex_a ? FWD_MEM : (w_mem_a ? FWD_WB : FWD_RF);
   assign w_fwd_b  = w_ex_b ? FWD_MEM : (w_mem_b ? FWD_WB : FWD_RF);
`else
   assign w_hazard = w_ex_a | w_ex_b | w_mem_a | w_mem_b;
   assign w_fwd_a  = FWD_RF;
   assign w_fwd_b  = FWD_RF;
`endif

   // Flush beats stall beats issue.
   assign flush   = branch_taken;
   assign stall   = w_hazard & id_valid & ~branch_taken;
   assign bubble  = stall | flush;
   assign w_issue = id_valid & ~stall & ~branch_taken;

   // Shadow entry for the instruction leaving ID.
   always_comb begin
      w_id_entry         = '0;
      w_id_entry.valid   = 1'b1;
      w_id_entry.wr      = w_wr;
      w_id_entry.dest    = SH_DEST_W'(w_dest);
      w_id_entry.is_load = w_is_load;
   end

   // Shadow pipe advances every edge; non-issue cycles inject an invalid entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex  <= '0;
         r_mem <= '0;
         r_wb  <= '0;
      end else begin
         r_wb  <= r_mem;
         r_mem <= r_ex;
         r_ex  <= w_issue ? w_id_entry : '0;
      end
   end

   // Forward selects follow the issued instruction into EX; bubbles read the regfile.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fwd_a <= FWD_RF;
         r_fwd_b <= FWD_RF;
      end else begin
         r_fwd_a <= w_issue ? w_fwd_a : FWD_RF;
         r_fwd_b <= w_issue ? w_fwd_b : FWD_RF;
      end
   end

   // Stall-accounting state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_RUN;
      else     r_state <= w_state_nxt;
   end

   // Stall-accounting next state; a taken branch wins from any state.
   always_comb begin
      w_state_nxt = r_state;
      if (branch_taken) begin
         w_state_nxt = ST_FLUSH;
      end else begin
         case (r_state)
            ST_RUN:   if (stall)  w_state_nxt = ST_STALL;
            ST_STALL: if (!stall) w_state_nxt = ST_RUN;
            ST_FLUSH: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
         endcase
      end
   end

   // Saturating count of cycles spent in STALL.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_count <= '0;
      end else if ((r_state == ST_STALL) && (r_stall_count != {STALL_CW{1'b1}})) begin
         r_stall_count <= r_stall_count + STALL_CW'(1);
      end
   end

   assign fwd_a_sel   = r_fwd_a;
   assign fwd_b_sel   = r_fwd_b;
   assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: directed and randomized checks of hazard_scheduler
// against an instruction-level reference model. A second instance with a
// 4-bit counter exercises saturation in reasonable time.
module tb_hazard_scheduler;

`ifdef HAZARD_FORWARD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0;
   logic [31:0] id_ir = '0;
   logic        branch_taken = 1'b0;

   logic        stall, bubble, flush;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic [15:0] stall_count;
   logic        s_stall, s_bubble, s_flush;
   logic [1:0]  s_fwd_a, s_fwd_b;
   logic [3:0]  s_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_scheduler u_dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ir(id_ir),
      .branch_taken(branch_taken), .stall(stall), .bubble(bubble), .flush(flush),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_count(stall_count)
   );

   hazard_scheduler #(.STALL_CW(4)) u_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ir(id_ir),
      .branch_taken(branch_taken), .stall(s_stall), .bubble(s_bubble), .flush(s_flush),
      .fwd_a_sel(s_fwd_a), .fwd_b_sel(s_fwd_b), .stall_count(s_count)
   );

   // ---------------- reference model (instruction level) ----------------
   int         m_dst [3];   // in-flight destinations EX/MEM/WB, -1 = none
   bit         m_ld  [3];
   int         m_state;     // 0 run, 1 stall, 2 flush
   int         m_cnt;
   logic [1:0] m_fa, m_fb;
   bit         p_rst = 1'b1, p_issue, p_stall, p_bt, p_ld;
   int         p_dest;
   logic [1:0] p_fa, p_fb;
   bit         e_stall, e_bubble, e_flush;

   logic [5:0] ops [11] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08,
                            6'h0c, 6'h0e, 6'h0b, 6'h03, 6'h3f};

   function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd, input int fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   function automatic logic [31:0] mk_i(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic int sat(input int v, input int lim);
      return (v > lim) ? lim : v;
   endfunction

   function automatic void decode(input logic [31:0] ir, output int dest,
                                  output int sa, output int sb, output bit ld);
      int op = int'(ir[31:26]);
      int rs = int'(ir[25:21]);
      int rt = int'(ir[20:16]);
      int rd = int'(ir[15:11]);
      dest = -1; sa = -1; sb = -1; ld = 1'b0;
      case (op)
         'h00:                  begin dest = rd; sa = rs; sb = rt; end
         'h23:                  begin dest = rt; sa = rs; ld = 1'b1; end
         'h2b, 'h04, 'h05:      begin sa = rs; sb = rt; end
         'h08, 'h0c, 'h0e, 'h0b: begin dest = rt; sa = rs; end
         'h03:                  dest = 31;
         default: ;
      endcase
      if (dest == 0) dest = -1;
      if (sa == 0) sa = -1;
      if (sb == 0) sb = -1;
   endfunction

   function automatic logic [1:0] fwd_src(input int s);
      if (!FWD_ON || s < 0) return 2'b00;
      if (s == m_dst[0]) return 2'b01;
      if (s == m_dst[1]) return 2'b10;
      return 2'b00;
   endfunction

   function automatic void model_commit();
      if (p_rst) begin
         for (int k = 0; k < 3; k++) begin m_dst[k] = -1; m_ld[k] = 1'b0; end
         m_cnt = 0; m_state = 0; m_fa = 2'b00; m_fb = 2'b00;
      end else begin
         if (m_state == 1) m_cnt++;
         m_dst[2] = m_dst[1]; m_ld[2] = m_ld[1];
         m_dst[1] = m_dst[0]; m_ld[1] = m_ld[0];
         m_dst[0] = p_issue ? p_dest : -1;
         m_ld[0]  = p_issue ? p_ld : 1'b0;
         m_fa     = p_issue ? p_fa : 2'b00;
         m_fb     = p_issue ? p_fb : 2'b00;
         if (p_bt)              m_state = 2;
         else if (m_state == 2) m_state = 0;
         else                   m_state = p_stall ? 1 : 0;
      end
   endfunction

   function automatic void model_eval(input bit r, input bit v, input logic [31:0] ir, input bit bt);
      int d, sa, sb;
      bit ld, haz;
      decode(ir, d, sa, sb, ld);
      haz = 1'b0;
      for (int k = 0; k < 2; k++)
         if (m_dst[k] >= 0 && (sa == m_dst[k] || sb == m_dst[k]))
            if (!FWD_ON || (k == 0 && m_ld[0])) haz = 1'b1;
      e_flush  = bt;
      e_stall  = haz && v && !bt;
      e_bubble = e_stall || e_flush;
      p_issue  = v && !e_stall && !bt;
      p_dest   = d;
      p_ld     = ld;
      p_stall  = e_stall;
      p_bt     = bt;
      p_rst    = r;
      p_fa     = fwd_src(sa);
      p_fb     = fwd_src(sb);
   endfunction

   // One clock: commit the model at the edge, drive inputs, sample at negedge.
   task automatic step(input bit r, input bit v, input logic [31:0] ir, input bit bt);
      @(posedge clk);
      model_commit();
      #1;
      rst = r; id_valid = v; id_ir = ir; branch_taken = bt;
      model_eval(r, v, ir, bt);
      @(negedge clk);
   endtask

   // lw $2,0($1) ; add $3,$2,$4 -- returns stall cycles, add's fwd_a and final count.
   task automatic run_load_use(input bit do_reset, output int nst, output logic [1:0] fa,
                               output logic [15:0] cnt);
      logic [31:0] lw_i  = mk_i('h23, 1, 2, 0);
      logic [31:0] add_i = mk_r(2, 4, 3, 'h20);
      if (do_reset) step(1, 0, '0, 0);
      step(0, 1, lw_i, 0);
      step(0, 1, add_i, 0);
      nst = 0;
      while (stall === 1'b1 && nst < 6) begin
         nst++;
         step(0, 1, add_i, 0);
      end
      step(0, 0, '0, 0);
      fa  = fwd_a_sel;
      cnt = stall_count;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      step(1, 0, '0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, '0, 0);
         total++;
         if ({stall, bubble, flush} !== 3'b000) begin
            bad++; $display("FAIL reset_ctl got=%b exp=000", {stall, bubble, flush});
         end
         total++;
         if ({fwd_a_sel, fwd_b_sel, stall_count} !== 20'h0) begin
            bad++; $display("FAIL reset_regs got=%h exp=00000", {fwd_a_sel, fwd_b_sel, stall_count});
         end
      end
   endtask

   task automatic test_load_use();
      int nst; logic [1:0] fa; logic [15:0] cnt;
      run_load_use(1'b1, nst, fa, cnt);
      total++;
      if (nst !== (FWD_ON ? 1 : 2)) begin
         bad++; $display("FAIL load_use_stalls got=%0d exp=%0d", nst, FWD_ON ? 1 : 2);
      end
      total++;
      if (fa !== (FWD_ON ? 2'b10 : 2'b00)) begin
         bad++; $display("FAIL load_use_fwd_a got=%b exp=%b", fa, FWD_ON ? 2'b10 : 2'b00);
      end
      total++;
      if (cnt !== 16'(FWD_ON ? 1 : 2)) begin
         bad++; $display("FAIL load_use_count got=%0d exp=%0d", cnt, FWD_ON ? 1 : 2);
      end
   endtask

   task automatic test_alu_fwd();
      int nst = 0;
      logic [31:0] sub_i = mk_r(5, 5, 6, 'h22);
      step(1, 0, '0, 0);
      step(0, 1, mk_r(1, 1, 5, 'h20), 0);
      step(0, 1, sub_i, 0);
      while (stall === 1'b1 && nst < 6) begin
         nst++;
         step(0, 1, sub_i, 0);
      end
      step(0, 0, '0, 0);
      total++;
      if (nst !== (FWD_ON ? 0 : 2)) begin
         bad++; $display("FAIL alu_stalls got=%0d exp=%0d", nst, FWD_ON ? 0 : 2);
      end
      total++;
      if ({fwd_a_sel, fwd_b_sel} !== (FWD_ON ? 4'b0101 : 4'b0000)) begin
         bad++; $display("FAIL alu_fwd got=%b exp=%b", {fwd_a_sel, fwd_b_sel}, FWD_ON ? 4'b0101 : 4'b0000);
      end
   endtask

   task automatic test_zero_reg();
      step(1, 0, '0, 0);
      step(0, 1, mk_r(1, 1, 0, 'h20), 0);
      step(0, 1, mk_r(0, 0, 7, 'h25), 0);
      total++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL zero_reg_stall got=%b exp=0", stall);
      end
      step(0, 0, '0, 0);
      total++;
      if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
         bad++; $display("FAIL zero_reg_fwd got=%b exp=0000", {fwd_a_sel, fwd_b_sel});
      end
   endtask

   task automatic test_flush();
      step(1, 0, '0, 0);
      step(0, 1, mk_i('h23, 1, 2, 0), 0);
      step(0, 1, mk_r(2, 4, 3, 'h20), 1);
      total++;
      if ({flush, bubble, stall} !== 3'b110) begin
         bad++; $display("FAIL flush_ctl got=%b exp=110", {flush, bubble, stall});
      end
      // If the squashed add had reached EX, a reader of $3 would see it.
      step(0, 1, mk_r(3, 3, 8, 'h20), 0);
      total++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL flush_leak_stall got=%b exp=0", stall);
      end
      step(0, 0, '0, 0);
      total++;
      if ({fwd_a_sel, fwd_b_sel, stall_count} !== 20'h0) begin
         bad++; $display("FAIL flush_leak_regs got=%h exp=00000", {fwd_a_sel, fwd_b_sel, stall_count});
      end
   endtask

   task automatic test_reset_mid_stall();
      int nst; logic [1:0] fa; logic [15:0] cnt;
      step(1, 0, '0, 0);
      step(0, 1, mk_i('h23, 1, 2, 0), 0);
      step(0, 1, mk_r(2, 4, 3, 'h20), 0);
      total++;
      if (stall !== 1'b1) begin
         bad++; $display("FAIL mid_stall_pre got=%b exp=1", stall);
      end
      step(1, 1, mk_r(2, 4, 3, 'h20), 0);
      step(0, 1, mk_r(2, 4, 3, 'h20), 0);
      total++;
      if ({stall, stall_count} !== 17'h0) begin
         bad++; $display("FAIL mid_stall_cleared got=%h exp=00000", {stall, stall_count});
      end
      run_load_use(1'b0, nst, fa, cnt);
      total++;
      if ({nst[3:0], fa, cnt} !== {4'(FWD_ON ? 1 : 2), (FWD_ON ? 2'b10 : 2'b00), 16'(FWD_ON ? 1 : 2)}) begin
         bad++; $display("FAIL mid_stall_repeat got=%0d/%b/%0d exp=%0d/%b/%0d", nst, fa, cnt,
                         FWD_ON ? 1 : 2, FWD_ON ? 2'b10 : 2'b00, FWD_ON ? 1 : 2);
      end
   endtask

   task automatic test_saturation();
      logic [31:0] chain = FWD_ON ? mk_i('h23, 2, 2, 0) : mk_r(2, 2, 2, 'h20);
      step(1, 0, '0, 0);
      for (int i = 0; i < 60; i++) step(0, 1, chain, 0);
      total++;
      if (s_count !== 4'hF) begin
         bad++; $display("FAIL sat_small got=%0d exp=15", s_count);
      end
      total++;
      if (stall_count !== 16'(sat(m_cnt, 65535))) begin
         bad++; $display("FAIL sat_wide got=%0d exp=%0d", stall_count, sat(m_cnt, 65535));
      end
   endtask

   task automatic test_random();
      logic [31:0] ir;
      step(1, 0, '0, 0);
      for (int i = 0; i < 400; i++) begin
         ir = {ops[$urandom_range(0, 10)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 11'($urandom)};
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), ir,
              ($urandom_range(0, 7) == 0));
         total++;
         if ({stall, bubble, flush, s_stall, s_bubble, s_flush} !==
             {e_stall, e_bubble, e_flush, e_stall, e_bubble, e_flush}) begin
            bad++; $display("FAIL rnd_ctl cyc=%0d got=%b%b%b/%b%b%b exp=%b%b%b", i, stall, bubble,
                            flush, s_stall, s_bubble, s_flush, e_stall, e_bubble, e_flush);
         end
         total++;
         if ({fwd_a_sel, fwd_b_sel, s_fwd_a, s_fwd_b} !== {m_fa, m_fb, m_fa, m_fb}) begin
            bad++; $display("FAIL rnd_fwd cyc=%0d got=%b%b exp=%b%b", i, fwd_a_sel, fwd_b_sel, m_fa, m_fb);
         end
         total++;
         if ({stall_count, s_count} !== {16'(sat(m_cnt, 65535)), 4'(sat(m_cnt, 15))}) begin
            bad++; $display("FAIL rnd_count cyc=%0d got=%0d/%0d exp=%0d/%0d", i, stall_count, s_count,
                            sat(m_cnt, 65535), sat(m_cnt, 15));
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_alu_fwd();
      test_zero_reg();
      test_flush();
      test_reset_mid_stall();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
